// File: rtl/lane_overlay_renderer_if.sv
// rtl/lane_overlay_renderer_if.sv - lane parameter, pixel stream and overlay output bundle
interface lane_overlay_renderer_if;
   logic        left_lane_valid;
   logic [9:0]  left_x_top;
   logic [9:0]  left_x_bottom;
   logic        right_lane_valid;
   logic [9:0]  right_x_top;
   logic [9:0]  right_x_bottom;
   logic        detection_done;
   logic        pixel_valid;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        frame_start;
   logic [15:0] rgb_in;
   logic        pixel_valid_out;
   logic [9:0]  pixel_x_out;
   logic [9:0]  pixel_y_out;
   logic        frame_start_out;
   logic [15:0] rgb_out;
   logic        overlay_armed;

   modport master (
      output left_lane_valid, left_x_top, left_x_bottom,
      output right_lane_valid, right_x_top, right_x_bottom,
      output detection_done, pixel_valid, pixel_x, pixel_y, frame_start, rgb_in,
      input  pixel_valid_out, pixel_x_out, pixel_y_out, frame_start_out, rgb_out, overlay_armed
   );

   modport slave (
      input  left_lane_valid, left_x_top, left_x_bottom,
      input  right_lane_valid, right_x_top, right_x_bottom,
      input  detection_done, pixel_valid, pixel_x, pixel_y, frame_start, rgb_in,
      output pixel_valid_out, pixel_x_out, pixel_y_out, frame_start_out, rgb_out, overlay_armed
   );
endinterface

// File: rtl/lane_overlay_renderer.sv
// rtl/lane_overlay_renderer.sv - double-buffered lane parameters, shared slope divider, row accumulator overlay
module lane_overlay_renderer #(
   parameter int          IMG_WIDTH   = 640,
   parameter int          IMG_HEIGHT  = 480,
   parameter int          ROI_TOP     = 240,
   parameter int          ROI_BOTTOM  = 460,
   parameter int          HALF_W      = 1,
   parameter logic [15:0] LEFT_COLOR  = 16'hF800,
   parameter logic [15:0] RIGHT_COLOR = 16'h07E0
) (
   input logic               clk,
   input logic               rst_n,
   lane_overlay_renderer_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, DIV_L = 2'd1, DIV_R = 2'd2, ARMED = 2'd3} state_t;
   typedef struct packed {
      logic       vld;
      logic [9:0] top;
      logic [9:0] bot;
   } lane_p_t;

   localparam int                DIVISOR  = ROI_BOTTOM - ROI_TOP;
   localparam int                RW       = $clog2(DIVISOR + 1) + 1;
   localparam logic [RW-1:0]     DIV_V    = RW'(DIVISOR);
   localparam logic [9:0]        TOP_V    = 10'(ROI_TOP);
   localparam logic [9:0]        BOT_V    = 10'(ROI_BOTTOM);
   localparam logic [9:0]        XLAST_V  = 10'(IMG_WIDTH - 1);
   localparam logic [9:0]        YLIM_V   = 10'(IMG_HEIGHT);
   localparam logic signed [11:0] HW_V    = 12'(HALF_W);
   localparam logic [4:0]        LAST_BIT = 5'd17;

   function automatic logic [17:0] abs_dvd(input logic [9:0] top, input logic [9:0] bot);
      logic [9:0] d;
      d = (bot >= top) ? (bot - top) : (top - bot);
      return {d, 8'd0};
   endfunction

   function automatic logic signed [18:0] apply_sign(input logic [17:0] q, input logic neg);
      logic signed [18:0] m;
      m = $signed({1'b0, q});
      return neg ? -m : m;
   endfunction

   state_t             state_q, state_d;
   lane_p_t            pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   lane_p_t            act_l_q, act_l_d, act_r_q, act_r_d;
   logic               pend_flag_q, pend_flag_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [17:0]        dvd_q, dvd_d;
   logic [RW-2:0]      rem_q, rem_d;
   logic [16:0]        quo_q, quo_d;
   logic signed [18:0] slope_l_q, slope_l_d, slope_r_q, slope_r_d;
   logic signed [18:0] xfp_l_q, xfp_l_d, xfp_r_q, xfp_r_d;
   logic               overlay_armed_q, overlay_armed_d;
   logic               pv_q, pv_d, fs_q, fs_d;
   logic [9:0]         px_q, px_d, py_q, py_d;
   logic [15:0]        rgb_q, rgb_d;

   logic               promote, restart, div_active, div_last;
   logic [RW-1:0]      rem_sh, rem_nx;
   logic               ge;
   logic [17:0]        quo_nx;
   logic signed [11:0] cx_l, cx_r, dx_l, dx_r;
   logic               in_roi, row_step, draw_l, draw_r;

   // Promotion only consumes what was pending before this cycle; a coincident capture stays pending.
   assign promote = bus.frame_start && pend_flag_q;
   assign restart = bus.frame_start && (promote || state_q == DIV_L || state_q == DIV_R);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = DIV_L;
      end else begin
         case (state_q)
            DIV_L:   if (cnt_q == LAST_BIT) state_d = DIV_R;
            DIV_R:   if (cnt_q == LAST_BIT) state_d = ARMED;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      div_active      = (state_q == DIV_L) || (state_q == DIV_R);
      div_last        = div_active && (cnt_q == LAST_BIT);
      overlay_armed_d = (state_q == ARMED) && !promote;
   end

   always_comb begin
      rem_sh = {rem_q, dvd_q[17]};
      ge     = (rem_sh >= DIV_V);
      rem_nx = ge ? (rem_sh - DIV_V) : rem_sh;
      quo_nx = {quo_q, ge};
   end

   always_comb begin
      pend_l_d    = pend_l_q;
      pend_r_d    = pend_r_q;
      pend_flag_d = pend_flag_q;
      act_l_d     = act_l_q;
      act_r_d     = act_r_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      slope_l_d   = slope_l_q;
      slope_r_d   = slope_r_q;
      xfp_l_d     = xfp_l_q;
      xfp_r_d     = xfp_r_q;

      if (bus.detection_done) begin
         pend_l_d    = {bus.left_lane_valid, bus.left_x_top, bus.left_x_bottom};
         pend_r_d    = {bus.right_lane_valid, bus.right_x_top, bus.right_x_bottom};
         pend_flag_d = 1'b1;
      end else if (promote) begin
         pend_flag_d = 1'b0;
      end

      if (promote) begin
         act_l_d = pend_l_q;
         act_r_d = pend_r_q;
      end

      if (restart) begin
         cnt_d = '0;
         rem_d = '0;
         quo_d = '0;
         dvd_d = abs_dvd(act_l_d.top, act_l_d.bot);
      end else if (div_last) begin
         cnt_d = '0;
         rem_d = '0;
         quo_d = '0;
         if (state_q == DIV_L) begin
            slope_l_d = apply_sign(quo_nx, act_l_q.bot < act_l_q.top);
            dvd_d     = abs_dvd(act_r_q.top, act_r_q.bot);
         end else begin
            slope_r_d = apply_sign(quo_nx, act_r_q.bot < act_r_q.top);
         end
      end else if (div_active) begin
         cnt_d = cnt_q + 5'd1;
         rem_d = rem_nx[RW-2:0];
         quo_d = quo_nx[16:0];
         dvd_d = {dvd_q[16:0], 1'b0};
      end

      if (bus.frame_start) begin
         xfp_l_d = $signed({1'b0, act_l_d.top, 8'd0});
         xfp_r_d = $signed({1'b0, act_r_d.top, 8'd0});
      end else if (row_step) begin
         xfp_l_d = xfp_l_q + slope_l_q;
         xfp_r_d = xfp_r_q + slope_r_q;
      end
   end

   // Rounded row centre: (x_fp + 128) >> 8 is the integer part plus the half bit.
   always_comb begin
      row_step = bus.pixel_valid && (bus.pixel_x == XLAST_V) &&
                 (bus.pixel_y >= TOP_V) && (bus.pixel_y < BOT_V);
      in_roi   = (bus.pixel_y >= TOP_V) && (bus.pixel_y <= BOT_V) && (bus.pixel_y < YLIM_V);
      cx_l     = {xfp_l_q[18], xfp_l_q[18:8]} + {11'd0, xfp_l_q[7]};
      cx_r     = {xfp_r_q[18], xfp_r_q[18:8]} + {11'd0, xfp_r_q[7]};
      dx_l     = $signed({2'b00, bus.pixel_x}) - cx_l;
      dx_r     = $signed({2'b00, bus.pixel_x}) - cx_r;
      draw_l   = overlay_armed_q && act_l_q.vld && bus.pixel_valid && in_roi &&
                 (dx_l >= -HW_V) && (dx_l <= HW_V);
      draw_r   = overlay_armed_q && act_r_q.vld && bus.pixel_valid && in_roi &&
                 (dx_r >= -HW_V) && (dx_r <= HW_V);
      pv_d     = bus.pixel_valid;
      px_d     = bus.pixel_x;
      py_d     = bus.pixel_y;
      fs_d     = bus.frame_start;
      rgb_d    = draw_l ? LEFT_COLOR : (draw_r ? RIGHT_COLOR : bus.rgb_in);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_l_q        <= '0;
         pend_r_q        <= '0;
         pend_flag_q     <= 1'b0;
         act_l_q         <= '0;
         act_r_q         <= '0;
         cnt_q           <= '0;
         dvd_q           <= '0;
         rem_q           <= '0;
         quo_q           <= '0;
         slope_l_q       <= '0;
         slope_r_q       <= '0;
         xfp_l_q         <= '0;
         xfp_r_q         <= '0;
         overlay_armed_q <= 1'b0;
         pv_q            <= 1'b0;
         px_q            <= '0;
         py_q            <= '0;
         fs_q            <= 1'b0;
         rgb_q           <= '0;
      end else begin
         pend_l_q        <= pend_l_d;
         pend_r_q        <= pend_r_d;
         pend_flag_q     <= pend_flag_d;
         act_l_q         <= act_l_d;
         act_r_q         <= act_r_d;
         cnt_q           <= cnt_d;
         dvd_q           <= dvd_d;
         rem_q           <= rem_d;
         quo_q           <= quo_d;
         slope_l_q       <= slope_l_d;
         slope_r_q       <= slope_r_d;
         xfp_l_q         <= xfp_l_d;
         xfp_r_q         <= xfp_r_d;
         overlay_armed_q <= overlay_armed_d;
         pv_q            <= pv_d;
         px_q            <= px_d;
         py_q            <= py_d;
         fs_q            <= fs_d;
         rgb_q           <= rgb_d;
      end
   end

   assign bus.pixel_valid_out = pv_q;
   assign bus.pixel_x_out     = px_q;
   assign bus.pixel_y_out     = py_q;
   assign bus.frame_start_out = fs_q;
   assign bus.rgb_out         = rgb_q;
   assign bus.overlay_armed   = overlay_armed_q;
endmodule

// File: tb/tb_lane_overlay_renderer.sv
// tb/tb_lane_overlay_renderer.sv - probe table plus randomized frames against an arithmetic lane model
module tb_lane_overlay_renderer;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lane_overlay_renderer_if bus();
   lane_overlay_renderer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      bit lv; int lt; int lb;
      bit rv; int rt; int rb;
   } lane_t;

   typedef struct {
      int          scen;
      int          y;
      int          x;
      bit          pass;
      logic [15:0] color;
   } probe_t;

   probe_t tbl[$];
   int     hits[$];
   int     cur_scen;

   lane_t m_pend, m_act;
   bit    m_pflag, m_armed;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic addp(input int s, input int y, input int x, input bit p, input logic [15:0] c);
      tbl.push_back('{s, y, x, p, c});
      hits.push_back(0);
   endtask

   function automatic int mcx(input int top, input int bot, input int y);
      int d, q, s, acc;
      d   = bot - top;
      q   = ((d < 0) ? -d : d) * 256 / 220;
      s   = (d < 0) ? -q : q;
      acc = top * 256 + s * (y - 240);
      return (acc + 128) >>> 8;
   endfunction

   function automatic logic [15:0] mexp(input int y, input int x, input logic [15:0] rin);
      int dl, dr;
      if (!m_armed || y < 240 || y > 460) return rin;
      dl = x - mcx(m_act.lt, m_act.lb, y);
      dr = x - mcx(m_act.rt, m_act.rb, y);
      if (m_act.lv && dl >= -1 && dl <= 1) return 16'hF800;
      if (m_act.rv && dr >= -1 && dr <= 1) return 16'h07E0;
      return rin;
   endfunction

   task automatic set_lane(input lane_t p);
      bus.left_lane_valid  = p.lv;
      bus.left_x_top       = 10'(p.lt);
      bus.left_x_bottom    = 10'(p.lb);
      bus.right_lane_valid = p.rv;
      bus.right_x_top      = 10'(p.rt);
      bus.right_x_bottom   = 10'(p.rb);
   endtask

   task automatic drive_px(input bit v, input int x, input int y);
      logic [15:0] rin, want;
      rin  = 16'($urandom);
      want = v ? mexp(y, x, rin) : rin;
      bus.pixel_valid = v;
      bus.pixel_x     = 10'(x);
      bus.pixel_y     = 10'(y);
      bus.rgb_in      = rin;
      @(posedge clk); #1;
      chk($sformatf("meta y%0d x%0d", y, x),
          {11'd0, bus.pixel_valid_out, bus.pixel_x_out, bus.pixel_y_out},
          {11'd0, v, 10'(x), 10'(y)});
      chk($sformatf("rgb y%0d x%0d", y, x), {16'd0, bus.rgb_out}, {16'd0, want});
      if (v) begin
         for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].scen == cur_scen && tbl[i].y == y && tbl[i].x == x) begin
               hits[i]++;
               chk($sformatf("probe s%0d y%0d x%0d", cur_scen, y, x), {16'd0, bus.rgb_out},
                   {16'd0, tbl[i].pass ? rin : tbl[i].color});
            end
         end
      end
      bus.pixel_valid = 1'b0;
   endtask

   task automatic det(input lane_t p);
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b0;
      set_lane(p);
      bus.detection_done = 1'b1;
      @(posedge clk); #1;
      bus.detection_done = 1'b0;
      m_pend  = p;
      m_pflag = 1'b1;
   endtask

   task automatic fstart(input bit with_dd, input lane_t p);
      bit promoted;
      int first;
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b1;
      if (with_dd) begin
         set_lane(p);
         bus.detection_done = 1'b1;
      end
      @(posedge clk); #1;
      bus.frame_start    = 1'b0;
      bus.detection_done = 1'b0;
      chk("frame_start_out", 32'(bus.frame_start_out), 32'd1);
      promoted = m_pflag;
      if (m_pflag) begin
         m_act   = m_pend;
         m_pflag = 1'b0;
         m_armed = 1'b1;
      end
      if (with_dd) begin
         m_pend  = p;
         m_pflag = 1'b1;
      end
      if (promoted) begin
         chk("armed_drop", 32'(bus.overlay_armed), 32'd0);
         first = 0;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.overlay_armed && first == 0) first = i;
         end
         chk("armed_latency", 32'(first), 32'd37);
      end else begin
         repeat (40) @(posedge clk);
         #1;
         chk("armed_hold", 32'(bus.overlay_armed), 32'(m_armed));
      end
   endtask

   task automatic frame(input int scen, input int dd_row, input lane_t mid_p);
      int tcols[$];
      int cols[$];
      int c;
      cur_scen = scen;
      foreach (tbl[i]) if (tbl[i].scen == scen) tcols.push_back(tbl[i].x);
      for (int y = 236; y <= 464; y++) begin
         if (y == dd_row) det(mid_p);
         cols = tcols;
         if (m_armed && m_act.lv) begin
            for (int k = -2; k <= 2; k++) begin
               c = mcx(m_act.lt, m_act.lb, y) + k;
               if (c >= 0 && c <= 638) cols.push_back(c);
            end
         end
         if (m_armed && m_act.rv) begin
            for (int k = -2; k <= 2; k++) begin
               c = mcx(m_act.rt, m_act.rb, y) + k;
               if (c >= 0 && c <= 638) cols.push_back(c);
            end
         end
         cols.push_back(int'($urandom_range(638)));
         foreach (cols[k]) begin
            if ($urandom_range(7) == 0)
               drive_px(1'b0, int'($urandom_range(639)), int'($urandom_range(479)));
            drive_px(1'b1, cols[k], y);
         end
         drive_px(1'b1, 639, y);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      lane_t p_none, p_v100, p_s1, p_s3, p_200, p_300, p_400, p_150, p;
      p_none = '{1'b0, 0, 0, 1'b0, 0, 0};
      p_v100 = '{1'b1, 100, 100, 1'b0, 500, 500};
      p_s1   = '{1'b1, 100, 320, 1'b0, 500, 500};
      p_s3   = '{1'b0, 100, 100, 1'b1, 500, 280};
      p_200  = '{1'b1, 200, 200, 1'b0, 500, 500};
      p_300  = '{1'b1, 300, 300, 1'b1, 300, 300};
      p_400  = '{1'b1, 400, 400, 1'b0, 0, 0};
      p_150  = '{1'b1, 150, 150, 1'b0, 0, 0};

      addp(0, 300, 100, 1, 16'h0);
      addp(1, 240,  99, 0, 16'hF800); addp(1, 240, 101, 0, 16'hF800);
      addp(1, 240,  98, 1, 16'h0);    addp(1, 240, 102, 1, 16'h0);
      addp(1, 239, 100, 1, 16'h0);    addp(1, 461, 100, 1, 16'h0);
      addp(1, 460, 100, 0, 16'hF800); addp(1, 350, 101, 0, 16'hF800);
      addp(2, 240, 100, 0, 16'hF800); addp(2, 350, 210, 0, 16'hF800);
      addp(2, 460, 320, 0, 16'hF800); addp(2, 460, 322, 1, 16'h0);
      addp(2, 350, 212, 1, 16'h0);
      addp(3, 460, 280, 0, 16'h07E0); addp(3, 460, 279, 0, 16'h07E0);
      addp(3, 240, 500, 0, 16'h07E0); addp(3, 240, 100, 1, 16'h0);
      addp(3, 350, 390, 0, 16'h07E0);
      addp(4, 300, 100, 0, 16'hF800); addp(4, 400, 100, 0, 16'hF800);
      addp(5, 300, 200, 0, 16'hF800); addp(5, 300, 100, 1, 16'h0);
      addp(6, 300, 299, 0, 16'hF800); addp(6, 300, 300, 0, 16'hF800);
      addp(6, 300, 301, 0, 16'hF800); addp(6, 300, 302, 1, 16'h0);
      addp(7, 300, 300, 0, 16'hF800);
      addp(8, 300, 400, 0, 16'hF800); addp(8, 300, 300, 1, 16'h0);
      addp(9, 300, 400, 1, 16'h0);
      addp(10, 300, 150, 0, 16'hF800);

      m_pend = p_none; m_act = p_none; m_pflag = 1'b0; m_armed = 1'b0;
      set_lane(p_none);
      bus.detection_done = 1'b0;
      bus.pixel_valid    = 1'b0;
      bus.pixel_x        = '0;
      bus.pixel_y        = '0;
      bus.frame_start    = 1'b0;
      bus.rgb_in         = 16'hABCD;

      repeat (3) @(posedge clk);
      #1;
      chk("reset rgb_out", 32'(bus.rgb_out), 32'd0);
      chk("reset valid_out", 32'(bus.pixel_valid_out), 32'd0);
      chk("reset fs_out", 32'(bus.frame_start_out), 32'd0);
      chk("reset armed", 32'(bus.overlay_armed), 32'd0);
      rst_n = 1'b1;

      fstart(1'b0, p_none); frame(0, -1, p_none);
      det(p_v100); fstart(1'b0, p_none); frame(1, -1, p_none);
      det(p_s1);   fstart(1'b0, p_none); frame(2, -1, p_none);
      det(p_s3);   fstart(1'b0, p_none); frame(3, -1, p_none);
      det(p_v100); fstart(1'b0, p_none); frame(4, 280, p_200);
      fstart(1'b0, p_none); frame(5, -1, p_none);
      det(p_300);  fstart(1'b0, p_none); frame(6, -1, p_none);
      fstart(1'b1, p_400); frame(7, -1, p_none);
      fstart(1'b0, p_none); frame(8, -1, p_none);

      // Reset asserted mid-row while a lane pixel is in flight.
      fstart(1'b0, p_none);
      cur_scen = 99;
      drive_px(1'b1, 10, 300);
      drive_px(1'b1, 400, 300);
      bus.pixel_valid = 1'b1;
      bus.pixel_x     = 10'd400;
      bus.pixel_y     = 10'd300;
      bus.rgb_in      = 16'h1234;
      @(posedge clk); #1;
      chk("pre_reset valid_out", 32'(bus.pixel_valid_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset rgb_out", 32'(bus.rgb_out), 32'd0);
      chk("midreset meta", {11'd0, bus.pixel_valid_out, bus.pixel_x_out, bus.pixel_y_out}, 32'd0);
      chk("midreset armed", 32'(bus.overlay_armed), 32'd0);
      @(posedge clk); #1;
      chk("held reset rgb_out", 32'(bus.rgb_out), 32'd0);
      bus.pixel_valid = 1'b0;
      rst_n = 1'b1;
      m_pend = p_none; m_act = p_none; m_pflag = 1'b0; m_armed = 1'b0;

      fstart(1'b0, p_none); frame(9, -1, p_none);
      det(p_150); fstart(1'b0, p_none); frame(10, -1, p_none);

      for (int r = 0; r < 4; r++) begin
         p.lv = 1'($urandom_range(1));
         p.lt = int'($urandom_range(639));
         p.lb = int'($urandom_range(639));
         p.rv = 1'($urandom_range(1));
         p.rt = int'($urandom_range(639));
         p.rb = int'($urandom_range(639));
         det(p);
         fstart(1'b0, p_none);
         frame(20 + r, -1, p_none);
      end

      foreach (tbl[i]) chk($sformatf("probe_hit %0d", i), 32'(hits[i] > 0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lane_overlay_renderer.md
Name: lane_overlay_renderer

Overview:
Consumer end of the lane-detection interface. It latches the lane line parameters produced at the end of each frame and renders the two lane lines onto the next frame's RGB565 pixel stream. Between the detector outputs and the display path, it uses a shared sequential divider for per-lane slope and a per-row fixed-point accumulator (no per-pixel division). Output is a 1-cycle-delayed copy of the input stream, with lane pixels recoloured.

Parameters:
IMG_WIDTH, 640, active pixels per row
IMG_HEIGHT, 480, rows per frame
ROI_TOP, 240, first row drawn; row where x_top applies
ROI_BOTTOM, 460, last row drawn; row where x_bottom applies (ROI_BOTTOM > ROI_TOP)
HALF_W, 1, line half-width in pixels (drawn width = 2*HALF_W+1)
LEFT_COLOR, 16'hF800, RGB565 colour for left lane
RIGHT_COLOR, 16'h07E0, RGB565 colour for right lane

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
left_lane_valid  in  1  left lane present (sampled on detection_done)
left_x_top  in  10  left x at ROI_TOP
left_x_bottom  in  10  left x at ROI_BOTTOM
right_lane_valid  in  1  right lane present
right_x_top  in  10  right x at ROI_TOP
right_x_bottom  in  10  right x at ROI_BOTTOM
detection_done  in  1  1-cycle pulse; parameters valid this cycle
pixel_valid  in  1  input pixel strobe
pixel_x  in  10  input column
pixel_y  in  10  input row
frame_start  in  1  1-cycle pulse before first pixel of frame
rgb_in  in  16  input pixel RGB565
pixel_valid_out  out  1  pixel_valid delayed 1 cycle
pixel_x_out  out  10  pixel_x delayed 1 cycle
pixel_y_out  out  10  pixel_y delayed 1 cycle
frame_start_out  out  1  frame_start delayed 1 cycle
rgb_out  out  16  overlaid pixel
overlay_armed  out  1  slopes valid; drawing enabled

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low; all outputs and internal registers clear to 0, and the FSM goes to IDLE.
- Pending buffer:
  - On detection_done, capture all six lane inputs into pending registers and set pend_flag.
  - A new detection_done overwrites pending.
- Promotion at frame_start:
  - If pend_flag is set, copy pending to active, clear pend_flag, drop overlay_armed, and enter DIV_L.
  - If pend_flag is clear, active and slopes are retained and overlay_armed is unchanged.
  - If detection_done and frame_start coincide: promote the pending contents held before that cycle; the new capture stays pending (pend_flag=1).
- FSM states: IDLE -> DIV_L -> DIV_R -> ARMED.
  - Restoring divider, one quotient bit per cycle, 18 cycles per lane.
  - dividend = |x_bottom - x_top| << 8 (18 bit); divisor = ROI_BOTTOM - ROI_TOP.
  - slope (19-bit signed, Q10.8) = sign(x_bottom - x_top) * quotient, truncated toward zero.
  - A lane whose active valid bit is 0 still runs its divide; its drawing is suppressed.
  - ARMED sets overlay_armed=1. ARMED -> DIV_L only via promotion.
  - frame_start during DIV_L/DIV_R restarts at DIV_L using the then-active values.
- Row accumulator (per lane, 19-bit signed Q11.8 x_fp):
  - On every frame_start, x_fp <= active x_top << 8. A frame_start that promotes loads the new x_top.
  - On pixel_valid with pixel_x == IMG_WIDTH-1 and ROI_TOP <= pixel_y < ROI_BOTTOM: x_fp += slope.
  - Row centre cx = (x_fp + 128) >> 8, with a signed compare.
  - Accumulated truncation error is < 1 px at ROI_BOTTOM.
- Draw condition, lane L:
  - Requires overlay_armed, the active valid bit, pixel_valid, and ROI_TOP <= pixel_y <= ROI_BOTTOM.
  - Also requires |pixel_x - cx| <= HALF_W, using a signed 12-bit difference.
  - Pixels with negative or out-of-range cx never match columns outside 0..IMG_WIDTH-1; no wrap.
- Output, registered, 1-cycle latency:
  - rgb_out = LEFT_COLOR if left draws, else RIGHT_COLOR if right draws, else rgb_in.
  - Left wins on overlap.
  - When pixel_valid=0: rgb_out = rgb_in and the delayed valid is 0.
- Startup: no drawing until the first detection_done has been followed by a frame_start and the divide has completed (36 cycles plus 1 to reach ARMED).

Test Plan:
- Vertical line: left valid, top=bottom=100, HALF_W=1, then frame → rows 240..460, x 99..101 = F800 one cycle later. Row 239, row 461 and x=98/102 pass rgb_in.
- Slope +1: left top=100, bottom=320 → slope=256. Centre at row 240=100, row 350=210, row 460=320.
- Slope −1: right top=500, bottom=280 → slope=−256. Centre at row 460=280. left_valid=0 → no F800 pixels anywhere.
- Double buffer: detection_done mid-frame with new x_top=200 → current frame keeps 100. Next frame draws at 200. overlay_armed low for 37 cycles after that frame_start.
- Overlap and coincidence: left and right both 300/300 → x 299..301 = F800. detection_done and frame_start in the same cycle → old params used, new params appear the frame after.
- Reset mid-frame (row 300): all outputs 0 and overlay_armed=0. Following frames pass rgb_in unchanged until a fresh detection_done + frame_start.
